// File: rtl/spi_ram_bank.sv
`default_nettype none
// ============================================================================
//  Module   : spi_ram_bank
//  Purpose  : Command-decoded single-port memory sitting between the SPI
//             receive shifter and the SPI transmit path. Two-bit commands
//             load independent write/read addresses or move one data word,
//             with optional post-access address auto-increment for bursts.
//             Data commands issued before their address command are
//             rejected with a one-cycle err pulse.
//  Ports    : clk       - rising-edge clock
//             rst       - synchronous active-high reset
//             rx_valid  - din carries a command this cycle
//             din       - {cmd[1:0], payload[DATA_WIDTH-1:0]}
//             dout      - read data, holds last value
//             tx_valid  - one-cycle pulse, dout is new
//             err       - one-cycle pulse, data command rejected
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module spi_ram_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,   // must not exceed DATA_WIDTH
  parameter int AUTO_INC   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH+1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  err
);

  localparam int         DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  wr_armed;
  logic                  rd_armed;

  logic [1:0]            cmd;
  logic [DATA_WIDTH-1:0] payload;
  logic                  wr_en;

  assign cmd     = din[DATA_WIDTH+1:DATA_WIDTH];
  assign payload = din[DATA_WIDTH-1:0];
  assign wr_en   = rx_valid && !rst && (cmd == CMD_WR_DATA) && wr_armed;

  // Memory contents survive reset, so the array lives in its own block.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
    end else begin
      // Both status outputs are pulses: cleared unless this command sets them.
      tx_valid <= 1'b0;
      err      <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: begin
            wr_addr  <= payload[ADDR_WIDTH-1:0];
            wr_armed <= 1'b1;
          end
          CMD_WR_DATA: begin
            if (wr_armed) begin
              // Increment wraps modulo depth by natural overflow.
              if (AUTO_INC != 0) begin
                wr_addr <= wr_addr + 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
          CMD_RD_ADDR: begin
            rd_addr  <= payload[ADDR_WIDTH-1:0];
            rd_armed <= 1'b1;
          end
          default: begin  // CMD_RD_DATA
            if (rd_armed) begin
              // A write issued on the previous command has already landed
              // in mem, so read-after-write returns the new word.
              dout     <= mem[rd_addr];
              tx_valid <= 1'b1;
              if (AUTO_INC != 0) begin
                rd_addr <= rd_addr + 1'b1;
              end
            end else begin
              err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_ram_bank.md
# spi_ram_bank

Parametrised command-decoded single-port memory behind the SPI slave. It is the next generation of the fixed 256x8 RAM and sits between the SPI receive shift logic (`rx_valid`/`din`) and the SPI transmit path (`tx_valid`/`dout`). It adds configurable data and address widths, optional address auto-increment for burst transfers, and an error pulse for data commands issued before their address command.

## Interface
- `DATA_WIDTH`, 8: memory word width; `din` is `DATA_WIDTH+2` bits.
- `ADDR_WIDTH`, 8: address width, must be at most `DATA_WIDTH`; depth is 2^ADDR_WIDTH.
- `AUTO_INC`, 1: when 1, the address increments after each data access; when 0, the address holds.

- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_valid`  in  1  `din` carries a command this cycle.
- `din`  in  DATA_WIDTH+2  `[DATA_WIDTH+1:DATA_WIDTH]` is the command; `[DATA_WIDTH-1:0]` is the payload.
- `dout`  out  DATA_WIDTH  read data; holds its last value.
- `tx_valid`  out  1  one-cycle pulse; `dout` is new this cycle.
- `err`  out  1  one-cycle pulse; data command rejected.

## Operation
- Internal state:
  - `wr_addr`, `rd_addr`: each ADDR_WIDTH bits.
  - `wr_armed`, `rd_armed`: flags.
  - memory array of 2^ADDR_WIDTH x DATA_WIDTH.
- Commands are acted on only at a rising edge with `rx_valid`=1 and `rst`=0. Command decode:
  - 00 WR_ADDR: `wr_addr` <= `din[ADDR_WIDTH-1:0]`; `wr_armed` <= 1.
  - 01 WR_DATA, if `wr_armed`: `mem[wr_addr]` <= `din[DATA_WIDTH-1:0]`; if AUTO_INC, `wr_addr` <= `wr_addr`+1.
  - 01 WR_DATA, if not armed: no write, `err` pulses.
  - 10 RD_ADDR: `rd_addr` <= `din[ADDR_WIDTH-1:0]`; `rd_armed` <= 1.
  - 11 RD_DATA, if `rd_armed`: `dout` <= `mem[rd_addr]`; `tx_valid` pulses; if AUTO_INC, `rd_addr` <= `rd_addr`+1.
  - 11 RD_DATA, if not armed: `dout` unchanged, `tx_valid`=0, `err` pulses.
- Payload bits above ADDR_WIDTH are ignored for address commands; the payload is ignored entirely for RD_DATA.
- Address increment is modulo 2^ADDR_WIDTH: all-ones wraps to 0. No error is raised on wrap.
- Write and read addresses are independent. An address command re-arms its flag and overwrites the address, including mid-burst.
- `rx_valid`=0: no state change; `tx_valid`=0 and `err`=0 next cycle.
- Read-after-write to the same address on consecutive commands returns the newly written data.
- Reset values: `dout`=0, `tx_valid`=0, `err`=0, both addresses 0, both armed flags 0. Memory contents are not reset.
- Reset mid-burst clears the armed flags. The next data command therefore errors until its address command is re-sent.

## Timing
- All outputs are registered and update on the same rising edge that samples the command. A response is visible in the cycle following the `rx_valid` cycle: one-cycle read latency.
- One command per cycle. Back-to-back commands are legal every cycle.
- Consecutive RD_DATA commands hold `tx_valid` high continuously, with a new `dout` each cycle.
- `tx_valid` and `err` are never high in the same cycle.
- `rst` has priority over `rx_valid` in the same cycle; the command is dropped.
- No backpressure: the downstream SPI transmit path must capture `dout` during the `tx_valid` cycle.

## Test plan
All scenarios use DATA_WIDTH=8 and ADDR_WIDTH=8; AUTO_INC=1 unless stated.
- Reset: hold `rst`=1 for 2 cycles with `rx_valid`=1 and `din`=0x3FF -> `dout`=0x00, `tx_valid`=0, `err`=0, and no memory write.
- Burst: send WR_ADDR 0x10, WR_DATA 0xAA, WR_DATA 0x55, RD_ADDR 0x10, RD_DATA, RD_DATA -> `dout`=0xAA then 0x55 on two consecutive `tx_valid` cycles, `err` never high.
- Wrap: send WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, RD_ADDR 0xFF, RD_DATA, RD_DATA -> `dout`=0x11 then 0x22 (second from address 0x00).
- Unarmed access after reset:
  - WR_DATA 0x33 -> `err` pulse, and a later read of address 0x00 does not return 0x33.
  - RD_DATA -> `err` pulse, `tx_valid`=0, `dout` unchanged.
- Reset mid-burst and idle: start the burst of the second scenario, assert `rst` for 1 cycle after the first RD_DATA, then send RD_DATA -> `err` pulse, no `tx_valid`. Separately, `rx_valid`=0 with `din`=0x300 -> no outputs change.
- AUTO_INC=0 instance: send WR_ADDR 0x05, WR_DATA 0x01, WR_DATA 0x02, RD_ADDR 0x05, RD_DATA, RD_DATA -> `dout`=0x02 on both `tx_valid` pulses.
